// File: rtl/ram_rd_check.sv
// ram_rd_check: read-data checker for a single-port RAM and its sequencer.
//
// Snoops the sequencer's RAM control bus and keeps a shadow copy of every
// write. Each read launches a tag {addr, expected data, shadow valid} into
// an RD_LAT-deep pipeline. When the tag reaches the end of the pipeline,
// the RAM's returned data is compared against the expected data.
//
// A sweep is a run of reads. It ends when the bus leaves the read phase,
// either on a write or on an idle cycle, and the last in-flight tag has
// been compared. Each completed sweep produces a verdict.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ram_en            bus cycle qualifier
//   ram_wr_H_rd_L     1 = write, 0 = read
//   ram_addr          RAM address
//   ram_wr_data       RAM write data
//   ram_rd_data       RAM read data, RD_LAT edges after the read
//   chk_valid         one-cycle pulse: a compare was performed
//   chk_err           one-cycle pulse: that compare mismatched
//   err_cnt           saturating mismatch count
//   sweep_done        one-cycle pulse at the end of a read sweep
//   sweep_ok          verdict of the last completed sweep
//   sweep_cnt         wrapping count of completed sweeps
//   err_sticky        set on the first mismatch since reset
//   first_err_addr    address of the first mismatch
//   first_err_exp     expected data of the first mismatch
//   first_err_got     received data of the first mismatch
module ram_rd_check #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en,
  input  logic              ram_wr_H_rd_L,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              chk_valid,
  output logic              chk_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sweep_done,
  output logic              sweep_ok,
  output logic [CNT_W-1:0]  sweep_cnt,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t state, state_nxt;

  logic wr_cyc, rd_cyc;
  assign wr_cyc = ram_en &  ram_wr_H_rd_L;
  assign rd_cyc = ram_en & ~ram_wr_H_rd_L;

  // Shadow memory; data is deliberately not reset, validity is.
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]  shadow_v;

  always_ff @(posedge clk) begin
    if (wr_cyc) shadow[ram_addr] <= ram_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shadow_v <= '0;
    else if (wr_cyc) shadow_v[ram_addr] <= 1'b1;
  end

  // Read-tag pipeline. p_occ marks a launched read (even to an unwritten
  // address) so the drain logic can see it; p_v gates the compare itself.
  logic [ADDR_W-1:0] p_addr [RD_LAT];
  logic [DATA_W-1:0] p_exp  [RD_LAT];
  logic [RD_LAT-1:0] p_occ, p_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_occ <= '0;
      p_v   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        p_addr[i] <= '0;
        p_exp[i]  <= '0;
      end
    end else begin
      p_occ[0]  <= rd_cyc;
      p_v[0]    <= rd_cyc & shadow_v[ram_addr];
      p_addr[0] <= ram_addr;
      p_exp[0]  <= shadow[ram_addr];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        p_occ[i]  <= p_occ[i-1];
        p_v[i]    <= p_v[i-1];
        p_addr[i] <= p_addr[i-1];
        p_exp[i]  <= p_exp[i-1];
      end
    end
  end

  logic cmp_now, mis_now;
  assign cmp_now = p_occ[RD_LAT-1] & p_v[RD_LAT-1];
  assign mis_now = cmp_now & (ram_rd_data != p_exp[RD_LAT-1]);

  // Tags still upstream of the final stage. The final-stage tag is compared
  // on the current edge, so once these are empty the sweep can close now.
  logic upstream_busy;
  always_comb begin
    upstream_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) upstream_busy |= p_occ[i];
  end

  logic exit_wr;
  logic sweep_fire;

  always_comb begin
    state_nxt  = state;
    sweep_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_cyc)      state_nxt = WRITE;
        else if (rd_cyc) state_nxt = READ;
      end
      WRITE: begin
        if (rd_cyc) state_nxt = READ;
      end
      READ: begin
        if (!rd_cyc) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rd_cyc) begin
          state_nxt = READ;
        end else if (!upstream_busy) begin
          sweep_fire = 1'b1;
          state_nxt  = exit_wr ? WRITE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       exit_wr <= 1'b0;
    else if (state == READ && !rd_cyc) exit_wr <= wr_cyc;
  end

  // Per-sweep accumulators; the compare landing on the closing edge is
  // folded into the verdict.
  logic sweep_cmp, sweep_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cmp  <= 1'b0;
      sweep_err  <= 1'b0;
      sweep_done <= 1'b0;
      sweep_ok   <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      sweep_done <= sweep_fire;
      if (sweep_fire) begin
        sweep_ok  <= (sweep_cmp | cmp_now) & ~(sweep_err | mis_now);
        sweep_cnt <= sweep_cnt + CNT_W'(1);
        sweep_cmp <= 1'b0;
        sweep_err <= 1'b0;
      end else begin
        if (cmp_now) sweep_cmp <= 1'b1;
        if (mis_now) sweep_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid      <= 1'b0;
      chk_err        <= 1'b0;
      err_cnt        <= '0;
      err_sticky     <= 1'b0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      chk_valid <= cmp_now;
      chk_err   <= mis_now;
      if (mis_now && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (mis_now && !err_sticky) begin
        err_sticky     <= 1'b1;
        first_err_addr <= p_addr[RD_LAT-1];
        first_err_exp  <= p_exp[RD_LAT-1];
        first_err_got  <= ram_rd_data;
      end
    end
  end

endmodule
